// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller
// and its datapath (IR opcode, ula flag, memory handshake).
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MentoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal_op;
  logic       mem_fault;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, IorD, MemRead, MemWrite,
    output IRWrite, MentoReg, RegDst, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSource,
    output state, illegal_op, mem_fault
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, IorD, MemRead, MemWrite,
    input  IRWrite, MentoReg, RegDst, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSource,
    input  state, illegal_op, mem_fault
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: per-state strobes, memory
// handshake stalls, timeout into a sticky FAULT state.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WCNT_W       = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    FAULT  = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [WCNT_W-1:0] WMAX =
    WCNT_W'(MEM_WAIT_MAX);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              ill_q, ill_d;
  logic              pc_write, branch;
  logic              mem_st, timeout;

  always_comb begin
    state_d      = state_q;
    ill_d        = ill_q;
    wcnt_d       = '0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MentoReg = 1'b0;
    bus.RegDst   = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.ALUOp    = 4'b0000;
    bus.PCSource = 2'b00;
    bus.mem_fault = 1'b0;

    mem_st  = (state_q == FETCH) ||
              (state_q == MEMRD) ||
              (state_q == MEMWR);
    timeout = mem_st && !bus.mem_ready &&
              (wcnt_q == WMAX);

    unique case (state_q)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          pc_write    = 1'b1;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          OP_R:     state_d = EXEC;
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_BEQ:   state_d = BRANCH;
          OP_ADDI,
          OP_ANDI,
          OP_ORI,
          OP_SLTI:  state_d = IEXEC;
          OP_J:     state_d = JUMP;
          default: begin
            ill_d   = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MentoReg = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 4'b0010;
        state_d     = RWB;
      end
      RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = 4'b0001;
        bus.PCSource = 2'b01;
        branch       = 1'b1;
        state_d      = FETCH;
      end
      IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (bus.opcode)
          OP_ANDI: bus.ALUOp = 4'b0011;
          OP_ORI:  bus.ALUOp = 4'b0100;
          OP_SLTI: bus.ALUOp = 4'b0101;
          default: bus.ALUOp = 4'b0000;
        endcase
        state_d = IWB;
      end
      IWB: begin
        bus.RegWrite = 1'b1;
        state_d      = FETCH;
      end
      JUMP: begin
        bus.PCSource = 2'b10;
        pc_write     = 1'b1;
        state_d      = FETCH;
      end
      FAULT: bus.mem_fault = 1'b1;
      default: state_d = FAULT;
    endcase

    if (timeout) state_d = FAULT;

    // Non-memory states and ready cycles leave the count at zero,
    // so every memory state is entered with a cleared counter.
    if (mem_st && !bus.mem_ready)
      wcnt_d = (wcnt_q == WMAX) ? wcnt_q
                                : wcnt_q + WCNT_W'(1);

    bus.pc_en      = pc_write | (branch & bus.zero);
    bus.state      = state_q;
    bus.illegal_op = ill_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      wcnt_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ill_q   <= ill_d;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: vector table,
// timeout/reset sequences and random instruction streams.
module tb_mips_multicycle_ctrl;
  logic clock = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic ill_m;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(
    .MEM_WAIT_MAX(15),
    .WCNT_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pce;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       mtr;
    logic       rd;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic [1:0] pcs;
    logic       flt;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic       ill;
  } vec_t;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // Expected outputs per state, straight from the state table.
  function automatic outs_t exp_out(
    input logic [3:0] st, input logic [5:0] op,
    input logic z, input logic rdy);
    outs_t o = '0;
    case (st)
      4'd0: begin
        o.mr = 1; o.srcb = 2'b01;
        o.irw = rdy; o.pce = rdy;
      end
      4'd1: o.srcb = 2'b11;
      4'd2: begin o.srca = 1; o.srcb = 2'b10; end
      4'd3: begin o.mr = 1; o.iord = 1; end
      4'd4: begin o.rw = 1; o.mtr = 1; end
      4'd5: begin o.mw = 1; o.iord = 1; end
      4'd6: begin o.srca = 1; o.aluop = 4'd2; end
      4'd7: begin o.rw = 1; o.rd = 1; end
      4'd8: begin
        o.srca = 1; o.aluop = 4'd1;
        o.pcs = 2'b01; o.pce = z;
      end
      4'd9: begin
        o.srca = 1; o.srcb = 2'b10;
        if (op == ANDI) o.aluop = 4'd3;
        else if (op == ORI) o.aluop = 4'd4;
        else if (op == SLTI) o.aluop = 4'd5;
      end
      4'd10: o.rw = 1;
      4'd11: begin o.pcs = 2'b10; o.pce = 1; end
      4'd15: o.flt = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic outs_t act();
    outs_t o;
    o.pce = bus.pc_en;      o.iord = bus.IorD;
    o.mr = bus.MemRead;     o.mw = bus.MemWrite;
    o.irw = bus.IRWrite;    o.mtr = bus.MentoReg;
    o.rd = bus.RegDst;      o.rw = bus.RegWrite;
    o.srca = bus.ALUSrcA;   o.srcb = bus.ALUSrcB;
    o.aluop = bus.ALUOp;    o.pcs = bus.PCSource;
    o.flt = bus.mem_fault;
    return o;
  endfunction

  task automatic cycle(
    input logic rst, input logic [5:0] op,
    input logic z, input logic rdy,
    input logic chk, input logic [3:0] est,
    input logic eill, input string tag);
    outs_t e, a;
    reset = rst;
    bus.opcode = op;
    bus.zero = z;
    bus.mem_ready = rdy;
    #2;
    if (chk) begin
      n_chk++;
      if (bus.state !== est) begin
        n_fail++;
        $display("FAIL %s state: got %0d want %0d",
                 tag, bus.state, est);
      end
      e = exp_out(est, op, z, rdy);
      a = act();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s outputs: got %h want %h",
                 tag, a, e);
      end
      n_chk++;
      if (bus.illegal_op !== eill) begin
        n_fail++;
        $display("FAIL %s illegal_op: got %b want %b",
                 tag, bus.illegal_op, eill);
      end
    end
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(
    input logic rst, input logic [5:0] op,
    input logic z, input logic rdy,
    input logic [3:0] st, input logic ill);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z;
    v.rdy = rdy; v.st = st; v.ill = ill;
    return v;
  endfunction

  function automatic int pick_wait();
    int r = $urandom_range(0, 39);
    if (r < 34) return r % 4;
    if (r < 37) return 15;
    return 16;
  endfunction

  // Instruction-level model: the state path is built from the
  // instruction class, memory states stretched by their wait count.
  task automatic run_instr(input logic [5:0] op);
    logic [3:0] path[$];
    logic       bad = 1'b0;
    logic [5:0] opd;
    int         w;
    path = '{4'd0, 4'd1};
    case (op)
      R:    path = {path, 4'd6, 4'd7};
      LW:   path = {path, 4'd2, 4'd3, 4'd4};
      SW:   path = {path, 4'd2, 4'd5};
      BEQ:  path = {path, 4'd8};
      ADDI, ANDI, ORI, SLTI:
            path = {path, 4'd9, 4'd10};
      JMP:  path = {path, 4'd11};
      default: bad = 1'b1;
    endcase
    foreach (path[i]) begin
      logic [3:0] s = path[i];
      opd = (s == 4'd0) ? 6'($urandom) : op;
      if (s == 4'd0 || s == 4'd3 || s == 4'd5) begin
        w = pick_wait();
        for (int k = 0; k < ((w > 15) ? 16 : w); k++)
          cycle(0, opd, 1'($urandom), 0, 1, s,
                ill_m, "rnd_wait");
        if (w > 15) begin
          cycle(0, opd, 1'($urandom), 1'($urandom),
                1, 4'd15, ill_m, "rnd_fault");
          cycle(0, opd, 1'($urandom), 1,
                1, 4'd15, ill_m, "rnd_fault");
          cycle(1, opd, 0, 0, 0, 4'd0, 0, "rnd_rst");
          ill_m = 1'b0;
          return;
        end
        cycle(0, opd, 1'($urandom), 1, 1, s,
              ill_m, "rnd_ready");
      end else begin
        cycle(0, opd, 1'($urandom), 1'($urandom),
              1, s, ill_m, "rnd_step");
      end
      if (s == 4'd1 && bad) ill_m = 1'b1;
    end
  endtask

  initial begin
    vec_t vq[$];
    logic [5:0] legal[9];
    legal = '{R, LW, SW, BEQ, ADDI,
              ANDI, ORI, SLTI, JMP};

    vq.push_back(mk(1, R, 0, 1, 0, 0));
    vq.push_back(mk(1, R, 0, 1, 0, 0));
    vq.push_back(mk(0, R, 0, 1, 0, 0));
    vq.push_back(mk(0, R, 0, 1, 1, 0));
    vq.push_back(mk(0, R, 0, 1, 6, 0));
    vq.push_back(mk(0, R, 0, 1, 7, 0));
    vq.push_back(mk(0, LW, 0, 1, 0, 0));
    vq.push_back(mk(0, LW, 0, 1, 1, 0));
    vq.push_back(mk(0, LW, 0, 1, 2, 0));
    vq.push_back(mk(0, LW, 0, 0, 3, 0));
    vq.push_back(mk(0, LW, 0, 0, 3, 0));
    vq.push_back(mk(0, LW, 0, 0, 3, 0));
    vq.push_back(mk(0, LW, 0, 1, 3, 0));
    vq.push_back(mk(0, LW, 0, 1, 4, 0));
    vq.push_back(mk(0, BEQ, 1, 1, 0, 0));
    vq.push_back(mk(0, BEQ, 1, 1, 1, 0));
    vq.push_back(mk(0, BEQ, 1, 1, 8, 0));
    vq.push_back(mk(0, BEQ, 0, 1, 0, 0));
    vq.push_back(mk(0, BEQ, 0, 1, 1, 0));
    vq.push_back(mk(0, BEQ, 0, 1, 8, 0));
    vq.push_back(mk(0, ORI, 0, 1, 0, 0));
    vq.push_back(mk(0, ORI, 0, 1, 1, 0));
    vq.push_back(mk(0, ORI, 0, 1, 9, 0));
    vq.push_back(mk(0, ORI, 0, 1, 10, 0));
    vq.push_back(mk(0, JMP, 0, 1, 0, 0));
    vq.push_back(mk(0, JMP, 0, 1, 1, 0));
    vq.push_back(mk(0, JMP, 0, 1, 11, 0));
    vq.push_back(mk(0, BAD, 0, 1, 0, 0));
    vq.push_back(mk(0, BAD, 0, 1, 1, 0));
    vq.push_back(mk(0, R, 0, 1, 0, 1));
    vq.push_back(mk(0, R, 0, 1, 1, 1));
    vq.push_back(mk(0, R, 0, 1, 6, 1));
    vq.push_back(mk(0, R, 0, 1, 7, 1));
    vq.push_back(mk(0, R, 0, 0, 0, 1));

    reset = 1'b1;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clock);
    #1;

    foreach (vq[i])
      cycle(vq[i].rst, vq[i].op, vq[i].z, vq[i].rdy,
            !vq[i].rst, vq[i].st, vq[i].ill,
            $sformatf("vec%0d", i));

    // FETCH timeout: 16 unready cycles, then absorbing FAULT.
    cycle(1, R, 0, 0, 0, 0, 0, "tmo_rst");
    for (int i = 0; i < 16; i++)
      cycle(0, R, 0, 0, 1, 4'd0, 0, "tmo_fetch");
    for (int i = 0; i < 3; i++)
      cycle(0, R, 1, 1, 1, 4'd15, 0, "tmo_fault");
    cycle(1, R, 0, 1, 0, 0, 0, "fault_rst");
    cycle(0, R, 0, 0, 1, 4'd0, 0, "post_fault_rst");

    // Reset mid-MEMWR also clears a sticky illegal_op.
    cycle(1, R, 0, 0, 0, 0, 0, "wr_rst0");
    cycle(0, R, 0, 1, 1, 4'd0, 0, "wr_f0");
    cycle(0, BAD, 0, 1, 1, 4'd1, 0, "wr_bad");
    cycle(0, R, 0, 1, 1, 4'd0, 1, "wr_f1");
    cycle(0, SW, 0, 1, 1, 4'd1, 1, "wr_dec");
    cycle(0, SW, 0, 1, 1, 4'd2, 1, "wr_adr");
    cycle(0, SW, 0, 0, 1, 4'd5, 1, "wr_wait");
    cycle(0, SW, 0, 0, 1, 4'd5, 1, "wr_wait");
    cycle(1, SW, 0, 0, 0, 0, 0, "wr_rst");
    cycle(0, SW, 0, 0, 1, 4'd0, 0, "post_wr_rst");

    cycle(1, R, 0, 0, 0, 0, 0, "rnd_rst0");
    ill_m = 1'b0;
    for (int n = 0; n < 250; n++) begin
      int r = $urandom_range(0, 10);
      run_instr(r < 9 ? legal[r] : 6'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
